// File: rtl/or3_tt_pkg.sv
// Shared definitions for gate truth-table sequencers.
// It holds the state encoding, the pattern count and the expected-value model for the 3-input OR.
// It contains no datapath or flow control.
package or3_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } tt_state_t;

    localparam int N_PATTERNS = 8;

    function automatic logic exp_or3(input logic [2:0] p);
        return p[2] | p[1] | p[0];
    endfunction

endpackage

// File: rtl/or3_tt_hold_timer.sv
// Hold counter for a single pattern: clr restarts it, en advances it, and last_o flags the final hold cycle.
// last_o is combinational from the count register.
// There is no backpressure; the owner decides when to clear it.
module hold_timer #(
    parameter int HOLD_CYCLES = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 8'(HOLD_CYCLES - 1));

endmodule

// File: rtl/or3_tt_sequencer.sv
// Sweeps {a,b,c} through 000..111 and checks the OR gate's y on the last hold cycle of each pattern.
// After start is accepted at edge E0, done rises after edge E0+8*HOLD_CYCLES.
// start is accepted only in IDLE or DONE; in DRIVE it is ignored.
module or3_tt_sequencer
    import or3_tt_pkg::*;
#(
    parameter int HOLD_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] fail_pattern
);

    localparam logic [2:0] P_LAST = 3'(N_PATTERNS - 1);

    tt_state_t  state_q, state_d;
    logic [2:0] p_q, p_d;
    logic [3:0] err_q, err_d;
    logic       fv_q, fv_d;
    logic [2:0] fp_q, fp_d;

    logic in_drive, accept, last, mismatch;

    assign in_drive = (state_q == ST_DRIVE);
    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign mismatch = (y != exp_or3(p_q));

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (accept || (in_drive && last)),
        .en_i  (in_drive),
        .last_o(last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = ST_DRIVE;
            ST_DRIVE:         if (last && p_q == P_LAST) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        p_d   = p_q;
        err_d = err_q;
        fv_d  = fv_q;
        fp_d  = fp_q;
        if (accept) begin
            p_d   = '0;
            err_d = '0;
            fv_d  = 1'b0;
            fp_d  = '0;
        end else if (in_drive && last) begin
            if (mismatch) begin
                err_d = err_q + 4'd1;
                if (!fv_q) begin
                    fv_d = 1'b1;
                    fp_d = p_q;
                end
            end
            if (p_q != P_LAST) begin
                p_d = p_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            err_q <= '0;
            fv_q  <= 1'b0;
            fp_q  <= '0;
        end else begin
            p_q   <= p_d;
            err_q <= err_d;
            fv_q  <= fv_d;
            fp_q  <= fp_d;
        end
    end

    // Pattern outputs come only from p_q/state_q, so they change only at clock edges.
    always_comb begin
        {a, b, c}    = in_drive ? p_q : 3'b000;
        busy         = in_drive;
        done         = (state_q == ST_DONE);
        pass         = done && (err_q == 4'd0);
        err_count    = err_q;
        fail_valid   = fv_q;
        fail_pattern = fp_q;
    end

endmodule

// File: tb/tb_or3_tt_sequencer.sv
// Randomized check of or3_tt_sequencer (HOLD_CYCLES 5 and 1) against a fault-mask reference model.
module tb_or3_tt_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       start5 = 1'b0, start1 = 1'b0;
    logic [7:0] mask5 = '0, mask1 = '0;

    logic       a5, b5, c5, busy5, done5, pass5, fv5, y5;
    logic [3:0] ec5;
    logic [2:0] fp5;
    logic       a1, b1, c1, busy1, done1, pass1, fv1, y1;
    logic [3:0] ec1;
    logic [2:0] fp1;

    // A set bit in the mask inverts the gate's answer for that pattern.
    assign y5 = (a5 | b5 | c5) ^ mask5[{a5, b5, c5}];
    assign y1 = (a1 | b1 | c1) ^ mask1[{a1, b1, c1}];

    or3_tt_sequencer #(.HOLD_CYCLES(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .y(y5),
        .a(a5), .b(b5), .c(c5), .busy(busy5), .done(done5), .pass(pass5),
        .err_count(ec5), .fail_valid(fv5), .fail_pattern(fp5)
    );

    or3_tt_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .fail_valid(fv1), .fail_pattern(fp1)
    );

    bit         sel = 1'b0;
    logic [2:0] abc_s, fp_s;
    logic [3:0] ec_s;
    logic       busy_s, done_s, pass_s, fv_s;

    always_comb begin
        abc_s  = sel ? {a1, b1, c1} : {a5, b5, c5};
        busy_s = sel ? busy1 : busy5;
        done_s = sel ? done1 : done5;
        pass_s = sel ? pass1 : pass5;
        fv_s   = sel ? fv1 : fv5;
        ec_s   = sel ? ec1 : ec5;
        fp_s   = sel ? fp1 : fp5;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int popc(input logic [7:0] m);
        int n = 0;
        for (int i = 0; i < 8; i++) if (m[i]) n++;
        return n;
    endfunction

    function automatic int first_bad(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start5 = v;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1 set_start(1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_abc"},  int'(abc_s),  0);
        chk({tag, "_busy"}, int'(busy_s), 0);
        chk({tag, "_done"}, int'(done_s), 0);
        chk({tag, "_pass"}, int'(pass_s), 0);
        chk({tag, "_ec"},   int'(ec_s),   0);
        chk({tag, "_fv"},   int'(fv_s),   0);
        chk({tag, "_fp"},   int'(fp_s),   0);
    endtask

    // One full sweep; inj1/inj2 are cycle offsets at which a stray start is raised mid-sweep.
    task automatic run_sweep(input int h, input logic [7:0] m, input int inj1, input int inj2);
        if (sel) mask1 = m;
        else     mask5 = m;
        pulse_start();
        chk("k0_done", int'(done_s), 0);
        for (int k = 0; k < 8 * h; k++) begin
            chk("pattern", int'(abc_s), k / h);
            chk("busy", int'(busy_s), 1);
            if (k == inj1 || k == inj2) set_start(1'b1);
            @(posedge clk);
            #1 set_start(1'b0);
        end
        chk("end_done", int'(done_s), 1);
        chk("end_busy", int'(busy_s), 0);
        chk("end_abc",  int'(abc_s),  0);
        chk("end_ec",   int'(ec_s),   popc(m));
        chk("end_pass", int'(pass_s), (popc(m) == 0) ? 1 : 0);
        chk("end_fv",   int'(fv_s),   (popc(m) != 0) ? 1 : 0);
        chk("end_fp",   int'(fp_s),   first_bad(m));
        @(posedge clk);
        #1 chk("done_hold", int'(done_s), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0; #1 check_idle_outputs("rst5");
        sel = 1'b1; #1 check_idle_outputs("rst1");
        @(negedge clk) rst = 1'b0;

        sel = 1'b0;
        run_sweep(5, 8'h00, -1, -1);
        run_sweep(5, 8'hFE, -1, -1);
        run_sweep(5, 8'h7E, -1, -1);
        run_sweep(5, 8'h00, 8, 18);
        run_sweep(5, 8'h00, 39, -1);
        repeat (6) run_sweep(5, 8'($urandom), -1, -1);

        // Reset in the middle of pattern 3 after one mismatch has been recorded.
        mask5 = 8'h02;
        pulse_start();
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_abc", int'(abc_s), 3);
        chk("pre_rst_ec",  int'(ec_s),  1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 check_idle_outputs("midrst");
        @(negedge clk) rst = 1'b0;
        run_sweep(5, 8'h00, -1, -1);

        sel = 1'b1;
        run_sweep(1, 8'h00, -1, -1);
        run_sweep(1, 8'h80, 3, -1);
        repeat (10) run_sweep(1, 8'($urandom), -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
